// File: rtl/compare_result_tracker.sv
// Consumes one-hot Greater/Equal/Lesser comparator flags, keeps saturating outcome counts,
// tracks consecutive Equal runs for lock detection and latches a sticky fault on illegal flags.
module compare_result_tracker #(
    parameter int CNT_W    = 8,
    parameter int STREAK_W = 4,
    parameter int LOCK_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                sample_en,
    input  logic                Greater,
    input  logic                Equal,
    input  logic                Lesser,
    output logic [CNT_W-1:0]    gt_count,
    output logic [CNT_W-1:0]    eq_count,
    output logic [CNT_W-1:0]    lt_count,
    output logic [STREAK_W-1:0] streak,
    output logic                locked,
    output logic                lock_lost,
    output logic                err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1'b1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1'b1);
    localparam logic [STREAK_W-1:0] LOCK_VAL   = STREAK_W'(LOCK_LEN);

    function automatic logic is_one_hot3(input logic [2:0] flags);
        return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    endfunction

    function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cnt);
        return (cnt == STREAK_MAX) ? cnt : cnt + STREAK_ONE;
    endfunction

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    gt_r, eq_r, lt_r;
    logic [CNT_W-1:0]    gt_s, eq_s, lt_s;
    logic [STREAK_W-1:0] streak_r, streak_s;
    logic                locked_r, locked_s;
    logic                lock_lost_r, lock_lost_s;
    logic                err_r, err_s;
    logic                take_s;
    logic                legal_s;

    assign take_s  = sample_en && !clear && (state_r != ST_FAULT);
    assign legal_s = is_one_hot3({Greater, Equal, Lesser});

    // Next-state and next-output computation for the tracking FSM.
    always_comb begin
        state_s     = state_r;
        gt_s        = gt_r;
        eq_s        = eq_r;
        lt_s        = lt_r;
        streak_s    = streak_r;
        lock_lost_s = 1'b0;
        if (clear) begin
            state_s  = ST_IDLE;
            gt_s     = {CNT_W{1'b0}};
            eq_s     = {CNT_W{1'b0}};
            lt_s     = {CNT_W{1'b0}};
            streak_s = {STREAK_W{1'b0}};
        end else if (take_s && !legal_s) begin
            // Illegal flags freeze all counts; only clear or reset leaves FAULT.
            state_s = ST_FAULT;
        end else if (take_s) begin
            if (Greater) begin
                gt_s = cnt_inc(gt_r);
            end else begin
                gt_s = gt_r;
            end
            if (Equal) begin
                eq_s     = cnt_inc(eq_r);
                streak_s = streak_inc(streak_r);
            end else begin
                eq_s     = eq_r;
                streak_s = {STREAK_W{1'b0}};
            end
            if (Lesser) begin
                lt_s = cnt_inc(lt_r);
            end else begin
                lt_s = lt_r;
            end
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_TRACK;
                end
                ST_TRACK: begin
                    if (Equal && (streak_s == LOCK_VAL)) begin
                        state_s = ST_LOCKED;
                    end else begin
                        state_s = ST_TRACK;
                    end
                end
                ST_LOCKED: begin
                    if (Equal) begin
                        state_s = ST_LOCKED;
                    end else begin
                        state_s     = ST_TRACK;
                        lock_lost_s = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_FAULT;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        locked_s = (state_s == ST_LOCKED);
        err_s    = (state_s == ST_FAULT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            gt_r        <= {CNT_W{1'b0}};
            eq_r        <= {CNT_W{1'b0}};
            lt_r        <= {CNT_W{1'b0}};
            streak_r    <= {STREAK_W{1'b0}};
            locked_r    <= 1'b0;
            lock_lost_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            gt_r        <= gt_s;
            eq_r        <= eq_s;
            lt_r        <= lt_s;
            streak_r    <= streak_s;
            locked_r    <= locked_s;
            lock_lost_r <= lock_lost_s;
            err_r       <= err_s;
        end
    end

    assign gt_count  = gt_r;
    assign eq_count  = eq_r;
    assign lt_count  = lt_r;
    assign streak    = streak_r;
    assign locked    = locked_r;
    assign lock_lost = lock_lost_r;
    assign err       = err_r;

endmodule

// File: tb/tb_compare_result_tracker.sv
// Table-driven bench for compare_result_tracker with a one-deep expected-result queue
// plus loops for saturation and an asynchronous mid-cycle reset.
module tb_compare_result_tracker;

    localparam int CNT_W    = 8;
    localparam int STREAK_W = 4;
    localparam int LOCK_LEN = 4;
    localparam int OUT_W    = 3 * CNT_W + STREAK_W + 3;

    localparam logic [2:0] F_G   = 3'b100;
    localparam logic [2:0] F_E   = 3'b010;
    localparam logic [2:0] F_L   = 3'b001;
    localparam logic [2:0] F_BAD = 3'b110;

    typedef logic [OUT_W-1:0] out_t;

    typedef struct {
        logic       clr;
        logic       en;
        logic [2:0] flags;
        out_t       exp;
        string      name;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clear;
    logic                sample_en;
    logic                Greater;
    logic                Equal;
    logic                Lesser;
    logic [CNT_W-1:0]    gt_count;
    logic [CNT_W-1:0]    eq_count;
    logic [CNT_W-1:0]    lt_count;
    logic [STREAK_W-1:0] streak;
    logic                locked;
    logic                lock_lost;
    logic                err;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    out_t sb[$];
    out_t act;

    compare_result_tracker #(
        .CNT_W   (CNT_W),
        .STREAK_W(STREAK_W),
        .LOCK_LEN(LOCK_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .sample_en(sample_en),
        .Greater  (Greater),
        .Equal    (Equal),
        .Lesser   (Lesser),
        .gt_count (gt_count),
        .eq_count (eq_count),
        .lt_count (lt_count),
        .streak   (streak),
        .locked   (locked),
        .lock_lost(lock_lost),
        .err      (err)
    );

    always #5 clk = ~clk;

    assign act = {gt_count, eq_count, lt_count, streak, locked, lock_lost, err};

    function automatic out_t mk(input int gt, input int eq, input int lt, input int stk,
                                input logic lk, input logic ll, input logic er);
        logic [31:0] g32, e32, l32, s32;
        g32 = gt;
        e32 = eq;
        l32 = lt;
        s32 = stk;
        return {g32[CNT_W-1:0], e32[CNT_W-1:0], l32[CNT_W-1:0], s32[STREAK_W-1:0], lk, ll, er};
    endfunction

    function automatic void add(input logic clr, input logic en, input logic [2:0] f,
                                input out_t e, input string nm);
        vec_t v;
        v.clr   = clr;
        v.en    = en;
        v.flags = f;
        v.exp   = e;
        v.name  = nm;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input out_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic clr, input logic en, input logic [2:0] f,
                        input out_t exp, input string nm);
        out_t e;
        clear     = clr;
        sample_en = en;
        {Greater, Equal, Lesser} = f;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h, expected an entry", nm, act);
        end else begin
            e = sb.pop_front();
            check(nm, e);
        end
    endtask

    initial begin
        // {gt, eq, lt, streak, locked, lock_lost, err}
        add(1'b0, 1'b1, F_E,   mk(0, 1, 0, 1, 1'b0, 1'b0, 1'b0), "eq1");
        add(1'b0, 1'b1, F_E,   mk(0, 2, 0, 2, 1'b0, 1'b0, 1'b0), "eq2");
        add(1'b0, 1'b1, F_E,   mk(0, 3, 0, 3, 1'b0, 1'b0, 1'b0), "eq3");
        add(1'b0, 1'b1, F_E,   mk(0, 4, 0, 4, 1'b1, 1'b0, 1'b0), "eq4_lock");
        add(1'b0, 1'b1, F_E,   mk(0, 5, 0, 5, 1'b1, 1'b0, 1'b0), "eq5_stay");
        add(1'b0, 1'b1, F_L,   mk(0, 5, 1, 0, 1'b0, 1'b1, 1'b0), "lt_break");
        add(1'b0, 1'b0, F_E,   mk(0, 5, 1, 0, 1'b0, 1'b0, 1'b0), "pulse_end");
        add(1'b0, 1'b1, F_E,   mk(0, 6, 1, 1, 1'b0, 1'b0, 1'b0), "gap_eq1");
        add(1'b0, 1'b0, 3'b111, mk(0, 6, 1, 1, 1'b0, 1'b0, 1'b0), "gap1_bad_ign");
        add(1'b0, 1'b0, 3'b000, mk(0, 6, 1, 1, 1'b0, 1'b0, 1'b0), "gap2");
        add(1'b0, 1'b0, F_G,   mk(0, 6, 1, 1, 1'b0, 1'b0, 1'b0), "gap3");
        add(1'b0, 1'b1, F_E,   mk(0, 7, 1, 2, 1'b0, 1'b0, 1'b0), "gap_eq2");
        add(1'b0, 1'b1, F_E,   mk(0, 8, 1, 3, 1'b0, 1'b0, 1'b0), "gap_eq3");
        add(1'b0, 1'b1, F_E,   mk(0, 9, 1, 4, 1'b1, 1'b0, 1'b0), "gap_lock");
        add(1'b0, 1'b1, F_G,   mk(1, 9, 1, 0, 1'b0, 1'b1, 1'b0), "gt_break");
        add(1'b0, 1'b1, F_G,   mk(2, 9, 1, 0, 1'b0, 1'b0, 1'b0), "gt2");
        add(1'b0, 1'b1, F_BAD, mk(2, 9, 1, 0, 1'b0, 1'b0, 1'b1), "fault_110");
        add(1'b0, 1'b1, F_G,   mk(2, 9, 1, 0, 1'b0, 1'b0, 1'b1), "fault_hold_g");
        add(1'b0, 1'b1, F_E,   mk(2, 9, 1, 0, 1'b0, 1'b0, 1'b1), "fault_hold_e");
        add(1'b1, 1'b1, F_E,   mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0), "clear_prio");
        add(1'b0, 1'b1, F_G,   mk(1, 0, 0, 0, 1'b0, 1'b0, 1'b0), "idle_gt");
        add(1'b1, 1'b1, 3'b000, mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0), "clear_bad");
        add(1'b0, 1'b1, 3'b000, mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b1), "fault_000");
        add(1'b1, 1'b0, 3'b000, mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0), "clear_fault");

        rst_n     = 1'b0;
        clear     = 1'b0;
        sample_en = 1'b0;
        Greater   = 1'b0;
        Equal     = 1'b0;
        Lesser    = 1'b0;
        #12;
        check("reset", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].en, vecs[i].flags, vecs[i].exp, vecs[i].name);
        end

        // Greater counter saturation: streak must stay 0.
        for (int k = 1; k <= 260; k++) begin
            step(1'b0, 1'b1, F_G, mk((k > 255) ? 255 : k, 0, 0, 0, 1'b0, 1'b0, 1'b0),
                 $sformatf("gt_sat_%0d", k));
        end

        step(1'b1, 1'b0, 3'b000, mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0), "clear2");

        // Equal saturation: eq_count holds at max while streak/lock keep advancing.
        for (int k = 1; k <= 256; k++) begin
            step(1'b0, 1'b1, F_E,
                 mk((k > 255) ? 255 : k, 0, 0, 0, 1'b0, 1'b0, 1'b0) == '0 ? '0 :
                 mk(0, (k > 255) ? 255 : k, 0, (k > 15) ? 15 : k, (k >= LOCK_LEN), 1'b0, 1'b0),
                 $sformatf("eq_sat_%0d", k));
        end
        step(1'b0, 1'b1, F_L, mk(0, 255, 1, 0, 1'b0, 1'b1, 1'b0), "sat_break");
        step(1'b0, 1'b1, F_E, mk(0, 255, 1, 1, 1'b0, 1'b0, 1'b0), "sat_reeq");
        step(1'b0, 1'b1, F_E, mk(0, 255, 1, 2, 1'b0, 1'b0, 1'b0), "sat_reeq2");
        step(1'b0, 1'b1, F_E, mk(0, 255, 1, 3, 1'b0, 1'b0, 1'b0), "sat_reeq3");
        step(1'b0, 1'b1, F_E, mk(0, 255, 1, 4, 1'b1, 1'b0, 1'b0), "sat_relock");

        // Asynchronous reset between edges while locked with nonzero counts.
        sample_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b1;
        step(1'b0, 1'b1, F_E, mk(0, 1, 0, 1, 1'b0, 1'b0, 1'b0), "post_reset_eq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
